// File: rtl/lsu_mem_access.sv
// Purpose: load/store unit turning one load/store into a single word-aligned bus request with byte lanes and extended load return.
// Latency: 3 cycles minimum (accept, REQ, DONE); each wait cycle of mem_ready adds one REQ cycle, aborted after TIMEOUT REQ cycles.
// Backpressure: stall holds the pipeline from acceptance until DONE; misaligned accesses never stall and never reach the bus.
module lsu_mem_access #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  WL,
    input  logic        extendSign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      off_q;
    logic [1:0]      wl_q;
    logic            sx_q;

    logic            start;
    logic            mis;
    logic [3:0]      be_nxt;
    logic [31:0]     wdata_nxt;
    logic [31:0]     lane;
    logic [31:0]     load_ext;

    // Request decode and alignment; WL=3 behaves as a word access.
    always_comb begin
        start = memRead | memWrite;
        mis   = 1'b0;
        if (WL == 2'b01)
            mis = addr[0];
        else if (WL[1])
            mis = |addr[1:0];
    end

    // Byte enables and lane-replicated store data for the bus word.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata;
        case (WL)
            2'b00: begin
                be_nxt    = 4'b0001 << addr[1:0];
                wdata_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << addr[1:0];
                wdata_nxt = {2{wdata[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = wdata;
            end
        endcase
    end

    // Shift the addressed lane down and extend it using the latched access shape.
    always_comb begin
        lane     = mem_rdata >> {off_q, 3'b000};
        load_ext = lane;
        case (wl_q)
            2'b00:   load_ext = sx_q ? {{24{lane[7]}}, lane[7:0]} : {24'd0, lane[7:0]};
            2'b01:   load_ext = sx_q ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // Same-cycle handshake to the pipeline; forced low while reset is held so a reset mid-access releases the pipeline at once.
    always_comb begin
        stall    = ~reset & ((state == REQ) | ((state == IDLE) & start & ~mis));
        misalign = ~reset & (state == IDLE) & start & mis;
    end

    // Access sequencer: accept, wait for the bus or time out, then report for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            to_cnt     <= '0;
            off_q      <= 2'b00;
            wl_q       <= 2'b00;
            sx_q       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !mis) begin
                        mem_req   <= 1'b1;
                        mem_we    <= memWrite;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_be    <= be_nxt;
                        mem_wdata <= wdata_nxt;
                        off_q     <= addr[1:0];
                        wl_q      <= WL;
                        sx_q      <= extendSign;
                        to_cnt    <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            load_data  <= load_ext;
                            load_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        mem_req   <= 1'b0;
                        load_data <= 32'd0;
                        bus_error <= 1'b1;
                        state     <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Inputs still belong to the completed instruction here.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
